alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Execute-stage front end that sits directly upstream of `alu`. It accepts a decoded data-processing instruction and forms the shifter operand (`Op2`) and the shifter carry-out from either a rotated immediate or a shifted `Rm`. It then presents these, registered, to the ALU inputs with a valid/ready handshake. Register-specified shifts take one extra cycle, matching the core's two-cycle issue for that instruction class.

## Interface
- `WIDTH`, default `` `WordWidth`` (32): datapath width; only 32 is supported.
- `in_Clock`  in  1  single clock, rising edge.
- `in_Reset`  in  1  reset, synchronous and active-high.
- `in_Valid`  in  1  upstream presents an instruction.
- `out_Ready`  out  1  stage can accept this cycle.
- `in_Opcode`  in  4  ALU opcode, passed through.
- `in_Set_cond`  in  1  S bit, passed through.
- `in_CNZV`  in  4  current flags; C is `[3]`.
- `in_Rn`, `in_Rm`, `in_Rs`  in  32  register operand values.
- `in_Imm`  in  1  I bit: Op2 is an immediate.
- `in_Shift`  in  12  instruction bits [11:0].
- `out_Valid`  out  1  ALU inputs hold a valid operation.
- `in_Ready`  in  1  downstream consumes this cycle.
- `out_Rn`, `out_Op2`  out  32  ALU operands.
- `out_Barrel_carry`  out  1  shifter carry-out.
- `out_Opcode`  out  4  registered opcode.
- `out_CNZV`  out  4  registered flags.
- `out_Set_cond`  out  1  registered S bit.
- `out_Undef`  out  1  unsupported shift form (see Configuration).

## Operation
- FSM states: EMPTY, SHIFT, FULL.
- `out_Ready` = (EMPTY) or (FULL and `in_Ready`). An accept is `in_Valid && out_Ready`.
- Accept with `in_Imm=1`, or with `in_Shift[4]=0`: compute Op2 and load the output registers; go to FULL.
- Accept with `in_Imm=0` and `in_Shift[4]=1`: latch all inputs; go to SHIFT. SHIFT always goes to FULL on the next cycle, computing from the latched values using `Rs[7:0]`.
- FULL with `in_Ready` and no new accept: go to EMPTY.
- Immediate path: Op2 = `in_Shift[7:0]` rotated right by 2×`in_Shift[11:8]`. Carry = C if the rotate amount is 0, else Op2[31].
- Immediate-amount shift: amount `[11:7]`, type `[6:5]` (00 LSL, 01 LSR, 10 ASR, 11 ROR).
  - LSL#0: Op2 = Rm, carry = C.
  - LSR#0 encodes LSR#32: Op2 = 0, carry = Rm[31].
  - ASR#0 encodes ASR#32: Op2 = {32{Rm[31]}}, carry = Rm[31].
  - ROR#0 encodes RRX: Op2 = {C, Rm[31:1]}, carry = Rm[0].
  - Nonzero amounts: standard shift; carry = last bit shifted out.
- Register-amount shift, amount n = `Rs[7:0]`:
  - n=0: Op2 = Rm, carry = C (all types).
  - LSL: n=32 gives 0 with carry Rm[0]; n>32 gives 0 with carry 0.
  - LSR: n=32 gives 0 with carry Rm[31]; n>32 gives 0 with carry 0.
  - ASR: n≥32 gives sign fill with carry Rm[31].
  - ROR: n[4:0]=0 (n≠0) gives Rm with carry Rm[31]; otherwise rotate by n[4:0].
- `out_Rn`, `out_Opcode`, `out_Set_cond` and `out_CNZV` are registered alongside Op2.

## Timing
- Reset: state EMPTY. All outputs 0 except `out_Ready`=1.
- Latency from accept to `out_Valid`: 1 cycle for immediate/immediate-shift; 2 cycles for register shift.
- Outputs hold stable while `out_Valid && !in_Ready`.
- FULL with `in_Ready=1` and `in_Valid=1`: drain and accept in the same cycle, giving back-to-back throughput of 1 per cycle.
- During SHIFT, `out_Ready`=0 and `out_Valid`=0.
- `in_Reset` in any state (including SHIFT) wins: the next cycle is EMPTY and in-flight data is discarded.

## Configuration
- `ALU_OPSTAGE_REGSHIFT_EN` defined: register-specified shifts are supported as above; `out_Undef` is tied 0.
- `ALU_OPSTAGE_REGSHIFT_EN` undefined: the SHIFT state and `Rs` latch are not built.
  - A `in_Shift[4]=1` accept goes directly to FULL with Op2 = Rm, carry = C, `out_Undef`=1.
  - `in_Rs` is ignored.

## Structure
- Shared definitions file next to `Def_ALUType.v`: shift-type encodings (LSL/LSR/ASR/ROR) and FSM state encodings.
- `` `WordWidth`` comes from `Def_StructureParameter.v`.
- One combinational sub-module, `barrel_shifter` (value, type, amount, amount-is-register flag, C in → Op2, carry), instantiated once and fed from a mux of live or latched inputs.

## Test plan
- Immediate: `in_Shift`=0x4FF, C=0 → Op2=0xFF000000, carry=1, `out_Valid` 1 cycle after accept.
- LSR#0, Rm=0x80000001 → Op2=0x00000000, carry=1.
- RRX, C=1, Rm=0x00000003 → Op2=0x80000001, carry=1.
- Register LSL, Rs=33, Rm=0xFFFFFFFF → Op2=0, carry=0. `out_Ready`=0 for the SHIFT cycle; `out_Valid` 2 cycles after accept. Also Rs=32 → Op2=0, carry=1.
- Back-pressure: hold `in_Ready`=0 for 3 cycles in FULL.
  - Outputs stay constant and `out_Ready`=0.
  - When `in_Ready` rises with `in_Valid`=1, a new op is accepted that cycle and appears on the next.
- Reset asserted during SHIFT → next cycle `out_Valid`=0, `out_Ready`=1, all data outputs 0.

Source files
------------

// File: rtl/alu_operand_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_pkg
// Shared definitions for the ALU operand stage.
//   WORD_WIDTH   : datapath width (32-bit core word)
//   shift_type_e : barrel-shift type encodings, as they appear in
//                  instruction bits [6:5]
//   state_e      : operand-stage FSM state encodings
// ---------------------------------------------------------------------------
package alu_operand_stage_pkg;

   localparam int WORD_WIDTH = 32;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_type_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_SHIFT = 2'b01,
      ST_FULL  = 2'b10
   } state_e;

endpackage

// File: rtl/alu_operand_stage_barrel_shifter.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_barrel_shifter
// Combinational shifter producing the data-processing operand Op2 and the
// shifter carry-out from Rm.
// Ports:
//   value_i   : Rm value to shift
//   type_i    : shift type (LSL/LSR/ASR/ROR)
//   amount_i  : shift amount; only [4:0] used for immediate-amount shifts,
//               full [7:0] (Rs[7:0]) for register-amount shifts
//   amt_reg_i : 1 = amount comes from a register (Rs)
//   carry_i   : current C flag
//   op2_o     : shifted operand
//   carry_o   : shifter carry-out
// ---------------------------------------------------------------------------
module alu_operand_stage_barrel_shifter
   import alu_operand_stage_pkg::*;
(
   input  logic [31:0] value_i,
   input  logic [1:0]  type_i,
   input  logic [7:0]  amount_i,
   input  logic        amt_reg_i,
   input  logic        carry_i,
   output logic [31:0] op2_o,
   output logic        carry_o
);

   logic [4:0]         amt5;
   logic [32:0]        lsl_w;
   logic [32:0]        lsr_w;
   logic signed [32:0] asr_w;
   logic [31:0]        ror_w;
   logic [31:0]        gen_op2;
   logic               gen_carry;

   assign amt5 = amount_i[4:0];

   // Shifts by 1..31. An extra bit on the side the data leaves from
   // catches the last bit shifted out, which is the carry.
   always_comb begin
      lsl_w = {1'b0, value_i} << amt5;
      lsr_w = {value_i, 1'b0} >> amt5;
      asr_w = $signed({value_i, 1'b0}) >>> amt5;
      ror_w = (value_i >> amt5) | (value_i << (6'd32 - {1'b0, amt5}));
      case (type_i)
         SH_LSL:  begin gen_op2 = lsl_w[31:0];  gen_carry = lsl_w[32]; end
         SH_LSR:  begin gen_op2 = lsr_w[32:1];  gen_carry = lsr_w[0];  end
         SH_ASR:  begin gen_op2 = asr_w[32:1];  gen_carry = asr_w[0];  end
         default: begin gen_op2 = ror_w;        gen_carry = ror_w[31]; end
      endcase
   end

   always_comb begin
      op2_o   = value_i;
      carry_o = carry_i;
      if (!amt_reg_i) begin
         if (amt5 != 5'd0) begin
            op2_o   = gen_op2;
            carry_o = gen_carry;
         end else begin
            // Amount 0 re-encodes LSR#32, ASR#32 and RRX; LSL#0 is a pass.
            case (type_i)
               SH_LSL: ;
               SH_LSR: begin op2_o = '0;                carry_o = value_i[31]; end
               SH_ASR: begin op2_o = {32{value_i[31]}}; carry_o = value_i[31]; end
               default: begin op2_o = {carry_i, value_i[31:1]}; carry_o = value_i[0]; end
            endcase
         end
      end else if (amount_i != 8'd0) begin
         if (amount_i[7:5] == 3'd0) begin
            op2_o   = gen_op2;
            carry_o = gen_carry;
         end else begin
            // Register amounts of 32 and above.
            case (type_i)
               SH_LSL: begin
                  op2_o   = '0;
                  carry_o = (amount_i == 8'd32) ? value_i[0] : 1'b0;
               end
               SH_LSR: begin
                  op2_o   = '0;
                  carry_o = (amount_i == 8'd32) ? value_i[31] : 1'b0;
               end
               SH_ASR: begin
                  op2_o   = {32{value_i[31]}};
                  carry_o = value_i[31];
               end
               default: begin
                  // Rotation is modulo 32; a multiple of 32 leaves Rm intact.
                  if (amt5 == 5'd0) begin
                     op2_o   = value_i;
                     carry_o = value_i[31];
                  end else begin
                     op2_o   = gen_op2;
                     carry_o = gen_carry;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
// Execute-stage front end feeding the ALU. Forms Op2 and the shifter carry
// from a rotated immediate or a shifted Rm and registers them, together with
// Rn, opcode, S bit and flags, behind a valid/ready handshake.
// Register-specified shifts spend one extra cycle in SHIFT.
//
// Build option: define ALU_OPSTAGE_REGSHIFT_EN to support register-specified
// shifts. Without it, such instructions pass Rm through with carry = C and
// raise out_Undef; in_Rs is ignored.
//
// Ports:
//   in_Clock, in_Reset (sync, active-high)
//   in_Valid / out_Ready            : upstream handshake
//   in_Opcode, in_Set_cond, in_CNZV : passed through (C = in_CNZV[3])
//   in_Rn, in_Rm, in_Rs             : register operand values
//   in_Imm, in_Shift[11:0]          : I bit and instruction bits [11:0]
//   out_Valid / in_Ready            : downstream handshake
//   out_Rn, out_Op2, out_Barrel_carry, out_Opcode, out_CNZV, out_Set_cond
//   out_Undef                       : unsupported shift form
// ---------------------------------------------------------------------------
module alu_operand_stage
   import alu_operand_stage_pkg::*;
#(
   parameter int WIDTH = WORD_WIDTH
) (
   input  logic             in_Clock,
   input  logic             in_Reset,
   input  logic             in_Valid,
   output logic             out_Ready,
   input  logic [3:0]       in_Opcode,
   input  logic             in_Set_cond,
   input  logic [3:0]       in_CNZV,
   input  logic [WIDTH-1:0] in_Rn,
   input  logic [WIDTH-1:0] in_Rm,
   input  logic [WIDTH-1:0] in_Rs,
   input  logic             in_Imm,
   input  logic [11:0]      in_Shift,
   output logic             out_Valid,
   input  logic             in_Ready,
   output logic [WIDTH-1:0] out_Rn,
   output logic [WIDTH-1:0] out_Op2,
   output logic             out_Barrel_carry,
   output logic [3:0]       out_Opcode,
   output logic [3:0]       out_CNZV,
   output logic             out_Set_cond,
   output logic             out_Undef
);

   state_e           state_q;
   logic [WIDTH-1:0] rn_q, op2_q;
   logic             carry_q, set_cond_q;
   logic [3:0]       opcode_q, cnzv_q;

   logic             accept;
   logic [WIDTH-1:0] imm_val, imm_op2;
   logic [4:0]       imm_rot;
   logic             imm_carry;

   logic [WIDTH-1:0] sh_value, sh_op2;
   logic [1:0]       sh_type;
   logic [7:0]       sh_amount;
   logic             sh_amt_reg, sh_cin, sh_carry;

   logic [WIDTH-1:0] op2_d;
   logic             carry_d;
   logic             unused_rs;

   assign out_Ready = (state_q == ST_EMPTY) || ((state_q == ST_FULL) && in_Ready);
   assign out_Valid = (state_q == ST_FULL);
   assign accept    = in_Valid && out_Ready;

   // 8-bit immediate rotated right by twice the 4-bit rotate field.
   assign imm_rot   = {in_Shift[11:8], 1'b0};
   assign imm_val   = {{(WIDTH-8){1'b0}}, in_Shift[7:0]};
   assign imm_op2   = (imm_val >> imm_rot) | (imm_val << (6'd32 - {1'b0, imm_rot}));
   assign imm_carry = (imm_rot == 5'd0) ? in_CNZV[3] : imm_op2[WIDTH-1];

`ifdef ALU_OPSTAGE_REGSHIFT_EN
   logic [WIDTH-1:0] rn_lat_q, rm_lat_q;
   logic [7:0]       rs_lat_q;
   logic [3:0]       opcode_lat_q, cnzv_lat_q;
   logic             set_cond_lat_q;
   logic [1:0]       type_lat_q;
   logic             sel_lat;
   logic             is_regshift;

   assign is_regshift = !in_Imm && in_Shift[4];
   assign unused_rs   = ^in_Rs[WIDTH-1:8];

   // While in SHIFT the single shifter works on the latched instruction.
   assign sel_lat    = (state_q == ST_SHIFT);
   assign sh_value   = sel_lat ? rm_lat_q         : in_Rm;
   assign sh_type    = sel_lat ? type_lat_q       : in_Shift[6:5];
   assign sh_amount  = sel_lat ? rs_lat_q         : {3'b000, in_Shift[11:7]};
   assign sh_amt_reg = sel_lat;
   assign sh_cin     = sel_lat ? cnzv_lat_q[3]    : in_CNZV[3];
   assign out_Undef  = 1'b0;

   // Register-shift instruction held for its second issue cycle.
   always_ff @(posedge in_Clock) begin
      if (accept && is_regshift) begin
         rn_lat_q       <= in_Rn;
         rm_lat_q       <= in_Rm;
         rs_lat_q       <= in_Rs[7:0];
         opcode_lat_q   <= in_Opcode;
         cnzv_lat_q     <= in_CNZV;
         set_cond_lat_q <= in_Set_cond;
         type_lat_q     <= in_Shift[6:5];
      end
   end
`else
   logic undef_q;
   logic undef_d;

   assign unused_rs  = ^in_Rs;
   assign sh_value   = in_Rm;
   assign sh_type    = in_Shift[6:5];
   assign sh_amount  = {3'b000, in_Shift[11:7]};
   assign sh_amt_reg = 1'b0;
   assign sh_cin     = in_CNZV[3];
   assign undef_d    = !in_Imm && in_Shift[4];
   assign out_Undef  = undef_q;
`endif

   alu_operand_stage_barrel_shifter u_shifter (
      .value_i   (sh_value),
      .type_i    (sh_type),
      .amount_i  (sh_amount),
      .amt_reg_i (sh_amt_reg),
      .carry_i   (sh_cin),
      .op2_o     (sh_op2),
      .carry_o   (sh_carry)
   );

   // Operand for a single-cycle accept.
   always_comb begin
      op2_d   = sh_op2;
      carry_d = sh_carry;
      if (in_Imm) begin
         op2_d   = imm_op2;
         carry_d = imm_carry;
      end
`ifndef ALU_OPSTAGE_REGSHIFT_EN
      else if (in_Shift[4]) begin
         op2_d   = in_Rm;
         carry_d = in_CNZV[3];
      end
`endif
   end

   always_ff @(posedge in_Clock) begin
      if (in_Reset) begin
         state_q    <= ST_EMPTY;
         rn_q       <= '0;
         op2_q      <= '0;
         carry_q    <= 1'b0;
         opcode_q   <= '0;
         cnzv_q     <= '0;
         set_cond_q <= 1'b0;
`ifndef ALU_OPSTAGE_REGSHIFT_EN
         undef_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
`ifdef ALU_OPSTAGE_REGSHIFT_EN
            ST_SHIFT: begin
               rn_q       <= rn_lat_q;
               op2_q      <= sh_op2;
               carry_q    <= sh_carry;
               opcode_q   <= opcode_lat_q;
               cnzv_q     <= cnzv_lat_q;
               set_cond_q <= set_cond_lat_q;
               state_q    <= ST_FULL;
            end
`endif
            ST_EMPTY, ST_FULL: begin
               if (accept) begin
`ifdef ALU_OPSTAGE_REGSHIFT_EN
                  if (is_regshift) begin
                     state_q <= ST_SHIFT;
                  end else
`endif
                  begin
                     rn_q       <= in_Rn;
                     op2_q      <= op2_d;
                     carry_q    <= carry_d;
                     opcode_q   <= in_Opcode;
                     cnzv_q     <= in_CNZV;
                     set_cond_q <= in_Set_cond;
`ifndef ALU_OPSTAGE_REGSHIFT_EN
                     undef_q    <= undef_d;
`endif
                     state_q    <= ST_FULL;
                  end
               end else if ((state_q == ST_FULL) && in_Ready) begin
                  state_q <= ST_EMPTY;
               end
            end
            default: state_q <= ST_EMPTY;
         endcase
      end
   end

   assign out_Rn           = rn_q;
   assign out_Op2          = op2_q;
   assign out_Barrel_carry = carry_q;
   assign out_Opcode       = opcode_q;
   assign out_CNZV         = cnzv_q;
   assign out_Set_cond     = set_cond_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_stage
// Directed and randomized bench for alu_operand_stage. Expected operands come
// from a bit-serial shift/rotate model; follows ALU_OPSTAGE_REGSHIFT_EN.
// ---------------------------------------------------------------------------
module tb_alu_operand_stage;

`ifdef ALU_OPSTAGE_REGSHIFT_EN
   localparam bit REGSHIFT = 1'b1;
`else
   localparam bit REGSHIFT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_Valid, in_Ready, in_Set_cond, in_Imm;
   logic [3:0]  in_Opcode, in_CNZV;
   logic [31:0] in_Rn, in_Rm, in_Rs;
   logic [11:0] in_Shift;
   logic        out_Ready, out_Valid, out_Barrel_carry, out_Set_cond, out_Undef;
   logic [31:0] out_Rn, out_Op2;
   logic [3:0]  out_Opcode, out_CNZV;

   int n_cmp  = 0;
   int n_fail = 0;

   // expected values of the op most recently presented
   logic [31:0] e_op2, e_rn;
   logic        e_c, e_undef, e_s, e_reg;
   logic [3:0]  e_opc, e_cnzv;

   always #5 clk = ~clk;

   alu_operand_stage dut (
      .in_Clock(clk), .in_Reset(rst), .in_Valid(in_Valid), .out_Ready(out_Ready),
      .in_Opcode(in_Opcode), .in_Set_cond(in_Set_cond), .in_CNZV(in_CNZV),
      .in_Rn(in_Rn), .in_Rm(in_Rm), .in_Rs(in_Rs), .in_Imm(in_Imm),
      .in_Shift(in_Shift), .out_Valid(out_Valid), .in_Ready(in_Ready),
      .out_Rn(out_Rn), .out_Op2(out_Op2), .out_Barrel_carry(out_Barrel_carry),
      .out_Opcode(out_Opcode), .out_CNZV(out_CNZV), .out_Set_cond(out_Set_cond),
      .out_Undef(out_Undef)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bit-at-a-time reference: each step moves one bit and records it as carry.
   function automatic void model(input logic imm, input logic [11:0] sh,
                                 input logic [31:0] rm, input logic [31:0] rs,
                                 input logic c, output logic [31:0] op2,
                                 output logic co, output logic undef);
      logic [31:0] v;
      logic        cc;
      int          n, kind;
      bit          done;
      v = rm; cc = c; op2 = rm; co = c; undef = 1'b0; done = 1'b0;
      kind = int'(sh[6:5]); n = 0;
      if (imm) begin
         v = {24'd0, sh[7:0]};
         n = 2 * int'(sh[11:8]);
         for (int i = 0; i < n; i++) v = {v[0], v[31:1]};
         op2 = v; co = (n == 0) ? c : v[31]; done = 1'b1;
      end else if (!sh[4]) begin
         n = int'(sh[11:7]);
         if (n == 0) begin
            if (kind == 0) begin op2 = rm; co = c; done = 1'b1; end
            else if (kind == 3) begin op2 = {c, rm[31:1]}; co = rm[0]; done = 1'b1; end
            else n = 32;
         end
      end else if (REGSHIFT) begin
         n = int'(rs[7:0]);
         if (n == 0) begin op2 = rm; co = c; done = 1'b1; end
         else if (kind == 3) begin
            n = n % 32;
            if (n == 0) begin op2 = rm; co = rm[31]; done = 1'b1; end
         end
      end else begin
         op2 = rm; co = c; undef = 1'b1; done = 1'b1;
      end
      if (!done) begin
         for (int i = 0; i < n; i++) begin
            case (kind)
               0:       begin cc = v[31]; v = v << 1;           end
               1:       begin cc = v[0];  v = v >> 1;           end
               2:       begin cc = v[0];  v = {v[31], v[31:1]}; end
               default: begin cc = v[0];  v = {v[0], v[31:1]};  end
            endcase
         end
         op2 = v; co = cc;
      end
   endfunction

   task automatic set_op(input logic imm, input logic [11:0] sh, input logic [31:0] rn,
                         input logic [31:0] rm, input logic [31:0] rs, input logic [3:0] cnzv,
                         input logic [3:0] opc, input logic s);
      in_Valid = 1'b1; in_Imm = imm; in_Shift = sh; in_Rn = rn; in_Rm = rm; in_Rs = rs;
      in_CNZV = cnzv; in_Opcode = opc; in_Set_cond = s;
      model(imm, sh, rm, rs, cnzv[3], e_op2, e_c, e_undef);
      e_rn = rn; e_opc = opc; e_cnzv = cnzv; e_s = s;
      e_reg = REGSHIFT && !imm && sh[4];
   endtask

   task automatic check_out(input string name);
      check({name, ".valid"}, out_Valid, 1);
      check({name, ".op2"}, out_Op2, e_op2);
      check({name, ".carry"}, out_Barrel_carry, e_c);
      check({name, ".rn"}, out_Rn, e_rn);
      check({name, ".opcode"}, out_Opcode, e_opc);
      check({name, ".cnzv"}, out_CNZV, e_cnzv);
      check({name, ".s"}, out_Set_cond, e_s);
      check({name, ".undef"}, out_Undef, e_undef);
   endtask

   // One op through an otherwise idle stage, then drained.
   task automatic run_op(input string name, input logic imm, input logic [11:0] sh,
                         input logic [31:0] rn, input logic [31:0] rm, input logic [31:0] rs,
                         input logic [3:0] cnzv, input logic [3:0] opc, input logic s);
      set_op(imm, sh, rn, rm, rs, cnzv, opc, s);
      in_Ready = 1'b1;
      #1;
      check({name, ".rdy_in"}, out_Ready, 1);
      tick();
      in_Valid = 1'b0;
      if (e_reg) begin
         check({name, ".shift_valid"}, out_Valid, 0);
         check({name, ".shift_ready"}, out_Ready, 0);
         tick();
      end
      check_out(name);
      tick();
      check({name, ".drained"}, out_Valid, 0);
   endtask

   logic [31:0] a_op2, a_rn;
   logic        a_c;
   logic [11:0] r_sh;
   logic [31:0] r_rs;

   initial begin
      rst = 1'b1; in_Valid = 1'b0; in_Ready = 1'b0; in_Imm = 1'b0; in_Shift = '0;
      in_Rn = '0; in_Rm = '0; in_Rs = '0; in_CNZV = '0; in_Opcode = '0; in_Set_cond = 1'b0;
      tick();
      tick();
      check("rst.valid", out_Valid, 0);
      check("rst.ready", out_Ready, 1);
      check("rst.op2", out_Op2, 0);
      check("rst.rn", out_Rn, 0);
      check("rst.carry", out_Barrel_carry, 0);
      check("rst.opcode", out_Opcode, 0);
      check("rst.cnzv", out_CNZV, 0);
      check("rst.s", out_Set_cond, 0);
      check("rst.undef", out_Undef, 0);
      rst = 1'b0;
      tick();

      // directed vectors
      run_op("imm4ff", 1'b1, 12'h4FF, 32'h11111111, 32'h0, 32'h0, 4'h0, 4'h4, 1'b1);
      check("imm4ff.const_op2", out_Op2, 32'hFF000000);
      check("imm4ff.const_c", out_Barrel_carry, 1);
      run_op("lsr32", 1'b0, 12'h020, 32'h2, 32'h80000001, 32'h0, 4'h0, 4'h2, 1'b0);
      check("lsr32.const_op2", out_Op2, 32'h0);
      check("lsr32.const_c", out_Barrel_carry, 1);
      run_op("rrx", 1'b0, 12'h060, 32'h3, 32'h00000003, 32'h0, 4'h8, 4'hD, 1'b1);
      check("rrx.const_op2", out_Op2, 32'h80000001);
      check("rrx.const_c", out_Barrel_carry, 1);
      run_op("asr32", 1'b0, 12'h040, 32'h4, 32'h80000000, 32'h0, 4'h0, 4'h1, 1'b0);
      run_op("lsl0", 1'b0, 12'h000, 32'h5, 32'hCAFEF00D, 32'h0, 4'h8, 4'h3, 1'b0);
      run_op("rlsl33", 1'b0, 12'h010, 32'h6, 32'hFFFFFFFF, 32'd33, 4'h0, 4'h5, 1'b1);
      check("rlsl33.const_op2", out_Op2, REGSHIFT ? 32'h0 : 32'hFFFFFFFF);
      check("rlsl33.const_c", out_Barrel_carry, 0);
      run_op("rlsl32", 1'b0, 12'h010, 32'h7, 32'hFFFFFFFF, 32'd32, 4'h0, 4'h6, 1'b0);
      check("rlsl32.const_op2", out_Op2, REGSHIFT ? 32'h0 : 32'hFFFFFFFF);
      check("rlsl32.const_c", out_Barrel_carry, REGSHIFT ? 1 : 0);
      run_op("rror32", 1'b0, 12'h070, 32'h8, 32'h80000010, 32'd64, 4'h0, 4'h7, 1'b0);
      run_op("rasr40", 1'b0, 12'h050, 32'h9, 32'h80000010, 32'd40, 4'h0, 4'h7, 1'b0);

      // back-pressure: op A held in FULL while op B waits
      set_op(1'b0, 12'h200, 32'hAAAA0001, 32'h12345678, 32'h0, 4'h4, 4'h9, 1'b1);
      in_Ready = 1'b0;
      #1;
      check("bp.rdyA", out_Ready, 1);
      tick();
      check_out("bp.A");
      a_op2 = e_op2; a_rn = e_rn; a_c = e_c;
      set_op(1'b1, 12'hA5C, 32'hBBBB0002, 32'h0, 32'h0, 4'h1, 4'hE, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp.hold_ready", out_Ready, 0);
         tick();
         check("bp.hold_valid", out_Valid, 1);
         check("bp.hold_op2", out_Op2, a_op2);
         check("bp.hold_rn", out_Rn, a_rn);
         check("bp.hold_c", out_Barrel_carry, a_c);
      end
      in_Ready = 1'b1;
      #1;
      check("bp.release_ready", out_Ready, 1);
      tick();
      check_out("bp.B");

      // back-to-back single-cycle ops
      for (int k = 0; k < 6; k++) begin
         r_sh = 12'($urandom);
         r_sh[4] = 1'b0;
         set_op(k[0], r_sh, $urandom, $urandom, $urandom, 4'($urandom), 4'($urandom), 1'($urandom));
         #1;
         check("b2b.ready", out_Ready, 1);
         tick();
         check_out("b2b");
      end
      in_Valid = 1'b0;
      tick();
      check("b2b.drained", out_Valid, 0);

      // reset while a register-shift op is in flight
      set_op(1'b0, 12'h030, 32'hDEADBEEF, 32'h87654321, 32'd3, 4'hF, 4'hB, 1'b1);
      in_Ready = 1'b0;
      tick();
      in_Valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstsh.valid", out_Valid, 0);
      check("rstsh.ready", out_Ready, 1);
      check("rstsh.op2", out_Op2, 0);
      check("rstsh.rn", out_Rn, 0);
      check("rstsh.carry", out_Barrel_carry, 0);
      check("rstsh.opcode", out_Opcode, 0);
      check("rstsh.cnzv", out_CNZV, 0);
      check("rstsh.s", out_Set_cond, 0);
      check("rstsh.undef", out_Undef, 0);
      in_Ready = 1'b1;
      tick();
      check("rstsh.after", out_Valid, 0);

      // randomized ops against the model
      for (int k = 0; k < 150; k++) begin
         r_sh = 12'($urandom);
         r_rs = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 40));
         run_op("rand", ($urandom_range(0, 2) == 0), r_sh, $urandom, $urandom, r_rs,
                4'($urandom), 4'($urandom), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
